// File: rtl/fetch_queue.sv
// Instruction fetch front end: single-outstanding word reads into a small FIFO,
// static predict-taken for BEQ, flushable by a decode-stage redirect.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clock,
    input  logic                     reset_n,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_gnt,
    input  logic                     imem_rvalid,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    output logic                     out_pred_taken,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int         AW   = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

    state_t                   state;
    logic [31:0]              fetch_pc;
    entry_t [DEPTH-1:0]       fifo;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count;
    entry_t                   head;
    logic                     push, pop, is_beq;
    logic [31:0]              br_off;

    assign is_beq = (imem_rdata[31:26] == 6'b000100);
    assign br_off = {{14{imem_rdata[15]}}, imem_rdata[15:0], 2'b00};

    // Redirect cancels both sides of the FIFO in the same cycle.
    assign push = (state == WAIT) & imem_rvalid & ~redirect;
    assign pop  = out_valid & out_ready & ~redirect;

    // Space is reserved at issue: occupancy < DEPTH guarantees the response fits.
    assign imem_req  = reset_n & (state == IDLE) & (count < FULL) & ~redirect;
    assign imem_addr = {fetch_pc[31:2], 2'b00};

    assign head           = fifo[rd_ptr];
    assign out_valid      = (count != '0);
    assign out_instr      = head.instr;
    assign out_pc         = head.pc;
    assign out_pred_taken = head.pred;
    assign occupancy      = count;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC & ~32'h3;
        end else begin
            case (state)
                IDLE: if (imem_req && imem_gnt) state <= WAIT;
                WAIT: begin
                    if (imem_rvalid)   state <= IDLE;
                    else if (redirect) state <= DROP;
                end
                DROP: if (imem_rvalid) state <= IDLE;
                default: state <= IDLE;
            endcase
            if (redirect)
                fetch_pc <= redirect_pc & ~32'h3;
            else if (push)
                fetch_pc <= fetch_pc + 32'd4 + (is_beq ? br_off : 32'd0);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                fifo[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc, pred: is_beq};
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
